// File: rtl/strobe_generator.sv
// Active-low strobe driver: one LOW_CYCLES-wide low pulse plus GAP_CYCLES high guard per request.
// Define STROBE_PENDING_EN to add a one-entry pending buffer for back-to-back strobes.
module strobe_generator #(
  parameter int LOW_CYCLES = 4,
  parameter int GAP_CYCLES = 2,
  parameter int CNT_W      = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  output logic signal_out,
  output logic busy,
  output logic done,
  output logic overrun
);

  typedef enum logic [1:0] {IDLE, LOW, GAP} state_t;

  localparam logic [CNT_W-1:0] LOW_LD = CNT_W'(LOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD = CNT_W'(GAP_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             signal_out_q, signal_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             overrun_q, overrun_d;
  logic             req_busy;
  logic             start_next;

`ifdef STROBE_PENDING_EN
  logic pend_q, pend_d;
`endif

  assign req_busy = req & busy_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    overrun_d  = 1'b0;
    start_next = 1'b0;
`ifdef STROBE_PENDING_EN
    pend_d = pend_q;
    if (req_busy) begin
      if (pend_q) overrun_d = 1'b1;
      else        pend_d    = 1'b1;
    end
    // A request landing on the final gap cycle goes straight into the next strobe.
    start_next = pend_d;
`else
    if (req_busy) overrun_d = 1'b1;
`endif
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = LOW;
          cnt_d   = LOW_LD;
        end
      end
      LOW: begin
        if (cnt_q == '0) begin
          state_d = GAP;
          cnt_d   = GAP_LD;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          if (start_next) begin
            state_d = LOW;
            cnt_d   = LOW_LD;
`ifdef STROBE_PENDING_EN
            pend_d  = 1'b0;
`endif
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Outputs are registered from the next state so they align with the state register.
    signal_out_d = (state_d != LOW);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      signal_out_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef STROBE_PENDING_EN
      pend_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      signal_out_q <= signal_out_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      overrun_q    <= overrun_d;
`ifdef STROBE_PENDING_EN
      pend_q       <= pend_d;
`endif
    end
  end

  assign signal_out = signal_out_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_strobe_generator.sv
// Bench for strobe_generator: a default-parameter instance and a LOW=1/GAP=1 instance
// driven by the same req, checked every cycle against a strobe-schedule model.
module tb_strobe_generator;
`ifdef STROBE_PENDING_EN
  localparam bit PEND = 1'b1;
`else
  localparam bit PEND = 1'b0;
`endif
  localparam int N = 4112;

  logic clk, rst, req;
  logic so[2], bz[2], dn[2], ov[2];
  int checks = 0, errors = 0, cyc = 0;

  // Expected per-cycle waveforms; cycle c is the interval after posedge number c.
  bit elo[2][N], ebz[2][N], edn[2][N], eov[2][N];
  int last_s[2];
  bit have[2];
  int lw[2] = '{4, 1};
  int gp[2] = '{2, 1};

  strobe_generator #(.LOW_CYCLES(4), .GAP_CYCLES(2), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .req(req),
    .signal_out(so[0]), .busy(bz[0]), .done(dn[0]), .overrun(ov[0]));

  strobe_generator #(.LOW_CYCLES(1), .GAP_CYCLES(1), .CNT_W(4)) u_min (
    .clk(clk), .rst(rst), .req(req),
    .signal_out(so[1]), .busy(bz[1]), .done(dn[1]), .overrun(ov[1]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      have[i] = 1'b0;
      for (int c = 0; c < N; c++) begin
        elo[i][c] = 1'b0; ebz[i][c] = 1'b0; edn[i][c] = 1'b0; eov[i][c] = 1'b0;
      end
    end
  endtask

  task automatic sched(int i, int s);
    last_s[i] = s;
    have[i]   = 1'b1;
    for (int c = s; c < s + lw[i]; c++) elo[i][c] = 1'b1;
    for (int c = s; c < s + lw[i] + gp[i]; c++) ebz[i][c] = 1'b1;
    edn[i][s + lw[i]] = 1'b1;
  endtask

  // Request sampled at edge e: idle -> strobe starts at e; a queued strobe already
  // waiting -> drop; otherwise buffer it behind the current one, or drop without buffer.
  task automatic step(bit r);
    int le;
    req = r;
    @(posedge clk);
    cyc++;
    if (!rst && r) begin
      for (int i = 0; i < 2; i++) begin
        le = last_s[i] + lw[i] + gp[i];
        if (!have[i] || cyc > le) sched(i, cyc);
        else if (last_s[i] >= cyc) eov[i][cyc] = 1'b1;
        else if (PEND) sched(i, le);
        else eov[i][cyc] = 1'b1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if ({so[i], bz[i], dn[i], ov[i]} !== 4'b1000) begin
          errors++;
          $display("FAIL reset u%0d k=%0d so/busy/done/ovr got %b%b%b%b want 1000", i, k, so[i], bz[i], dn[i], ov[i]);
        end
      end
      step(1'b0);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    for (int k = 0; k < 12; k++) begin
      step(k == 0);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if ({so[i], bz[i], dn[i], ov[i]} !== {~elo[i][cyc], ebz[i][cyc], edn[i][cyc], eov[i][cyc]}) begin
          errors++;
          $display("FAIL single u%0d cyc %0d got %b%b%b%b want %b%b%b%b", i, cyc, so[i], bz[i], dn[i], ov[i],
                   ~elo[i][cyc], ebz[i][cyc], edn[i][cyc], eov[i][cyc]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1); step(1'b0); step(1'b0);
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({so[0], bz[0], dn[0], ov[0]} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_mid_async so/busy/done/ovr got %b%b%b%b want 1000", so[0], bz[0], dn[0], ov[0]);
    end
    model_clear();
    for (int k = 0; k < 16; k++) begin
      if (k == 3) rst = 1'b0;
      step(k == 4);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if ({so[i], bz[i], dn[i], ov[i]} !== {~elo[i][cyc], ebz[i][cyc], edn[i][cyc], eov[i][cyc]}) begin
          errors++;
          $display("FAIL reset_mid u%0d cyc %0d got %b%b%b%b want %b%b%b%b", i, cyc, so[i], bz[i], dn[i], ov[i],
                   ~elo[i][cyc], ebz[i][cyc], edn[i][cyc], eov[i][cyc]);
        end
      end
    end
  endtask

  // pat bit k = request on step k
  task automatic test_pattern(string name, logic [31:0] pat, int len);
    for (int k = 0; k < len; k++) begin
      step(pat[k]);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if ({so[i], bz[i], dn[i], ov[i]} !== {~elo[i][cyc], ebz[i][cyc], edn[i][cyc], eov[i][cyc]}) begin
          errors++;
          $display("FAIL %s u%0d cyc %0d got %b%b%b%b want %b%b%b%b", name, i, cyc, so[i], bz[i], dn[i], ov[i],
                   ~elo[i][cyc], ebz[i][cyc], edn[i][cyc], eov[i][cyc]);
        end
      end
    end
  endtask

  task automatic test_random();
    int dens;
    dens = 30;
    for (int k = 0; k < 1500; k++) begin
      if (k % 100 == 0) dens = $urandom_range(5, 90);
      step(k < 1480 && $urandom_range(0, 99) < dens);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if ({so[i], bz[i], dn[i], ov[i]} !== {~elo[i][cyc], ebz[i][cyc], edn[i][cyc], eov[i][cyc]}) begin
          errors++;
          $display("FAIL random u%0d cyc %0d got %b%b%b%b want %b%b%b%b", i, cyc, so[i], bz[i], dn[i], ov[i],
                   ~elo[i][cyc], ebz[i][cyc], edn[i][cyc], eov[i][cyc]);
        end
      end
    end
  endtask

  initial begin
    req = 1'b0;
    rst = 1'b0;
    model_clear();
    #2 rst = 1'b1;
    #1;
    test_reset();
    test_single();
    test_reset_mid();
    test_pattern("back_to_back", 32'h0000_0005, 20);
    test_pattern("buffer_full",  32'h0000_000d, 20);
    test_pattern("no_buffer",    32'h0000_00c1, 22);
    test_pattern("min_held",     32'h000f_ffff, 28);
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
